// File: rtl/cdp1802_pkg.sv
// +----------------------------------------------------------------------+
// | cdp1802_pkg : boot loader state encoding and host frame field order  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package cdp1802_pkg;

   typedef enum logic [3:0] {
      ST_AH      = 4'd0,
      ST_AL      = 4'd1,
      ST_LH      = 4'd2,
      ST_LL      = 4'd3,
      ST_DATA    = 4'd4,
      ST_CSUM    = 4'd5,
      ST_RELEASE = 4'd6,
      ST_RUN     = 4'd7,
      ST_ERROR   = 4'd8
   } boot_state_t;

   // Byte offsets of the header fields; data follows, then one checksum byte.
   localparam int FRAME_ADDR_HI   = 0;
   localparam int FRAME_ADDR_LO   = 1;
   localparam int FRAME_LEN_HI    = 2;
   localparam int FRAME_LEN_LO    = 3;
   localparam int FRAME_HDR_BYTES = 4;

   // Checksum byte that makes (sum of data + csum) mod 256 equal zero.
   function automatic logic [7:0] frame_csum(input logic [7:0] data_sum);
      return 8'h00 - data_sum;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cdp1802_boot_loader.sv
// +----------------------------------------------------------------------+
// | cdp1802_boot_loader : loads a framed image into core RAM, verifies   |
// | its checksum, then releases the core and hands it the RAM port.      |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module cdp1802_boot_loader
   import cdp1802_pkg::*;
#(
   parameter int unsigned RESET_HOLD = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   input  logic        reload,
   output logic        cpu_resetq,
   input  logic        cpu_ram_rd,
   input  logic        cpu_ram_wr,
   input  logic [15:0] cpu_ram_a,
   input  logic [7:0]  cpu_ram_d,
   output logic        ram_rd,
   output logic        ram_wr,
   output logic [15:0] ram_a,
   output logic [7:0]  ram_d,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [7:0] HOLD_LAST = 8'(RESET_HOLD - 1);

   boot_state_t state_q;
   logic [15:0] addr_q;
   logic [15:0] len_q;
   logic [7:0]  csum_q;
   logic [7:0]  hold_q;
   logic        wr_q;
   logic [15:0] wr_a_q;
   logic [7:0]  wr_d_q;
   logic        cpu_resetq_q;
   logic        done_q;
   logic        err_q;

   logic        w_rx_state;
   logic        w_xfer;
   logic        w_run;
   logic [15:0] w_len_full;
   logic [7:0]  w_csum_total;

   assign w_rx_state   = (state_q == ST_AH)   || (state_q == ST_AL) ||
                         (state_q == ST_LH)   || (state_q == ST_LL) ||
                         (state_q == ST_DATA) || (state_q == ST_CSUM);
   // A byte offered alongside reload must not look consumed to the host.
   assign in_ready     = w_rx_state & ~reset & ~reload;
   assign busy         = w_rx_state & ~reset;
   assign w_xfer       = in_valid & in_ready;
   assign w_run        = (state_q == ST_RUN);
   assign w_len_full   = {len_q[15:8], in_data};
   assign w_csum_total = csum_q + in_data;

   assign ram_rd     = w_run ? cpu_ram_rd : 1'b0;
   assign ram_wr     = w_run ? cpu_ram_wr : wr_q;
   assign ram_a      = w_run ? cpu_ram_a  : wr_a_q;
   assign ram_d      = w_run ? cpu_ram_d  : wr_d_q;
   assign cpu_resetq = cpu_resetq_q;
   assign done       = done_q;
   assign err        = err_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_AH;
         addr_q       <= 16'h0000;
         len_q        <= 16'h0000;
         csum_q       <= 8'h00;
         hold_q       <= 8'h00;
         wr_q         <= 1'b0;
         wr_a_q       <= 16'h0000;
         wr_d_q       <= 8'h00;
         cpu_resetq_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else if (reload) begin
         state_q      <= ST_AH;
         wr_q         <= 1'b0;
         cpu_resetq_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         wr_q <= 1'b0;
         case (state_q)
            ST_AH: if (w_xfer) begin
               addr_q[15:8] <= in_data;
               csum_q       <= 8'h00;
               state_q      <= ST_AL;
            end
            ST_AL: if (w_xfer) begin
               addr_q[7:0] <= in_data;
               state_q     <= ST_LH;
            end
            ST_LH: if (w_xfer) begin
               len_q[15:8] <= in_data;
               state_q     <= ST_LL;
            end
            ST_LL: if (w_xfer) begin
               len_q[7:0] <= in_data;
               state_q    <= (w_len_full == 16'h0000) ? ST_CSUM : ST_DATA;
            end
            // len_q counts remaining bytes, so a full 65535-byte frame never overflows it.
            ST_DATA: if (w_xfer) begin
               wr_q   <= 1'b1;
               wr_a_q <= addr_q;
               wr_d_q <= in_data;
               addr_q <= addr_q + 16'd1;
               csum_q <= w_csum_total;
               len_q  <= len_q - 16'd1;
               if (len_q == 16'd1) begin
                  state_q <= ST_CSUM;
               end
            end
            ST_CSUM: if (w_xfer) begin
               if (w_csum_total == 8'h00) begin
                  state_q <= ST_RELEASE;
                  done_q  <= 1'b1;
                  hold_q  <= 8'h00;
               end else begin
                  state_q <= ST_ERROR;
                  err_q   <= 1'b1;
               end
            end
            ST_RELEASE: begin
               if (hold_q == HOLD_LAST) begin
                  state_q      <= ST_RUN;
                  cpu_resetq_q <= 1'b1;
               end else begin
                  hold_q <= hold_q + 8'd1;
               end
            end
            ST_RUN, ST_ERROR: begin
            end
            default: state_q <= ST_AH;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cdp1802_boot_loader.sv
// +----------------------------------------------------------------------+
// | tb_cdp1802_boot_loader : scoreboard bench for the cdp1802 boot loader |
// | Revision               : 1.0                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_cdp1802_boot_loader;
   import cdp1802_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = 8'h00;
   logic        reload = 1'b0;
   logic        cpu_resetq;
   logic        cpu_ram_rd = 1'b0;
   logic        cpu_ram_wr = 1'b0;
   logic [15:0] cpu_ram_a = 16'h0000;
   logic [7:0]  cpu_ram_d = 8'h00;
   logic        ram_rd;
   logic        ram_wr;
   logic [15:0] ram_a;
   logic [7:0]  ram_d;
   logic        busy;
   logic        done;
   logic        err;

   typedef struct packed {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   wr_t        exp_q[$];
   logic [7:0] payload[$];
   int         pass_cnt  = 0;
   int         total_cnt = 0;
   bit         mon_en    = 1'b1;

   always #5 clock = ~clock;

   cdp1802_boot_loader #(.RESET_HOLD(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .reload     (reload),
      .cpu_resetq (cpu_resetq),
      .cpu_ram_rd (cpu_ram_rd),
      .cpu_ram_wr (cpu_ram_wr),
      .cpu_ram_a  (cpu_ram_a),
      .cpu_ram_d  (cpu_ram_d),
      .ram_rd     (ram_rd),
      .ram_wr     (ram_wr),
      .ram_a      (ram_a),
      .ram_d      (ram_d),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   // Loader-side RAM writes are popped from the scoreboard as they appear.
   always @(negedge clock) begin
      if (mon_en && ram_wr) begin
         total_cnt++;
         if (exp_q.size() == 0) begin
            $display("FAIL ram_write unexpected: got a=%h d=%h, required no write", ram_a, ram_d);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if ({ram_a, ram_d} !== {e.a, e.d})
               $display("FAIL ram_write: got a=%h d=%h, required a=%h d=%h", ram_a, ram_d, e.a, e.d);
            else
               pass_cnt++;
         end
      end
      if (mon_en && ram_rd === 1'b1) begin
         total_cnt++;
         $display("FAIL loader_ram_rd: got 1, required 0");
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] good_csum();
      logic [7:0] s;
      s = 8'h00;
      foreach (payload[i]) s = s + payload[i];
      return 8'h00 - s;
   endfunction

   function automatic int pick_gap(input int m);
      if (m == 0) return 0;
      return int'($urandom_range(0, m));
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit ok;
      int n;
      for (int g = 0; g < gap; g++) begin
         in_valid = 1'b0;
         @(posedge clock); #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      n  = 0;
      ok = 1'b0;
      do begin
         @(negedge clock);
         ok = in_ready;
         @(posedge clock); #1;
         n++;
      end while (!ok && n < 50);
      in_valid = 1'b0;
      if (!ok) begin
         total_cnt++;
         $display("FAIL send_byte timeout: in_ready got 0 for 50 cycles, required 1 (byte %h)", b);
      end
   endtask

   task automatic send_frame(input logic [15:0] addr, input logic [7:0] cs, input int gap_max);
      logic [15:0] len;
      logic [15:0] cur;
      len = 16'(payload.size());
      cur = addr;
      send_byte(addr[15:8], pick_gap(gap_max));
      send_byte(addr[7:0],  pick_gap(gap_max));
      send_byte(len[15:8],  pick_gap(gap_max));
      send_byte(len[7:0],   pick_gap(gap_max));
      foreach (payload[i]) begin
         exp_q.push_back('{a: cur, d: payload[i]});
         cur = cur + 16'd1;
         send_byte(payload[i], pick_gap(gap_max));
      end
      send_byte(cs, pick_gap(gap_max));
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      @(posedge clock); #1;
      reload = 1'b0;
   endtask

   task automatic finish_good_frame(input string name);
      repeat (2) @(negedge clock);
      total_cnt++;
      if ({done, err} !== 2'b10)
         $display("FAIL %s flags: got done=%b err=%b, required done=1 err=0", name, done, err);
      else
         pass_cnt++;
      total_cnt++;
      if (exp_q.size() !== 0)
         $display("FAIL %s writes: got %0d pending, required 0", name, exp_q.size());
      else
         pass_cnt++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      total_cnt++;
      if ({in_ready, busy, cpu_resetq, done, err} !== 5'b0)
         $display("FAIL reset_ctrl: got rdy=%b busy=%b rq=%b done=%b err=%b, required all 0",
                  in_ready, busy, cpu_resetq, done, err);
      else
         pass_cnt++;
      total_cnt++;
      if ({ram_rd, ram_wr, ram_a, ram_d} !== 26'h0)
         $display("FAIL reset_ram: got rd=%b wr=%b a=%h d=%h, required all 0", ram_rd, ram_wr, ram_a, ram_d);
      else
         pass_cnt++;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      total_cnt++;
      if ({in_ready, busy} !== 2'b11)
         $display("FAIL reset_exit: got rdy=%b busy=%b, required 1 1", in_ready, busy);
      else
         pass_cnt++;
   endtask

   task automatic test_basic_frame();
      int bad;
      @(posedge clock); #1;
      payload = '{8'hA1, 8'hB2, 8'hC3};
      send_frame(16'h0010, 8'hEA, 0);
      bad = 0;
      for (int j = 0; j <= 4; j++) begin
         @(negedge clock);
         if (cpu_resetq !== (j == 4)) bad++;
      end
      total_cnt++;
      if (bad != 0)
         $display("FAIL release_timing: got %0d wrong cycles, required cpu_resetq rising 4 cycles after CSUM", bad);
      else
         pass_cnt++;
      total_cnt++;
      if ({done, err, busy, in_ready} !== 4'b1000)
         $display("FAIL basic_flags: got done=%b err=%b busy=%b rdy=%b, required 1 0 0 0", done, err, busy, in_ready);
      else
         pass_cnt++;
      total_cnt++;
      if (exp_q.size() !== 0)
         $display("FAIL basic_writes: got %0d pending, required 0", exp_q.size());
      else
         pass_cnt++;
   endtask

   task automatic test_run_mux_reload();
      @(posedge clock); #1;
      mon_en     = 1'b0;
      cpu_ram_rd = 1'b1;
      cpu_ram_a  = 16'h0000;
      @(negedge clock);
      total_cnt++;
      if ({ram_rd, ram_wr, ram_a} !== {1'b1, 1'b0, 16'h0000})
         $display("FAIL run_fetch: got rd=%b wr=%b a=%h, required 1 0 0000", ram_rd, ram_wr, ram_a);
      else
         pass_cnt++;
      @(posedge clock); #1;
      cpu_ram_rd = 1'b0;
      cpu_ram_wr = 1'b1;
      cpu_ram_a  = 16'h1234;
      cpu_ram_d  = 8'h55;
      @(negedge clock);
      total_cnt++;
      if ({ram_wr, ram_a, ram_d} !== {1'b1, 16'h1234, 8'h55})
         $display("FAIL run_write: got wr=%b a=%h d=%h, required 1 1234 55", ram_wr, ram_a, ram_d);
      else
         pass_cnt++;
      @(posedge clock); #1;
      pulse_reload();
      @(negedge clock);
      total_cnt++;
      if ({cpu_resetq, ram_wr, done} !== 3'b000)
         $display("FAIL run_reload: got rq=%b wr=%b done=%b, required 0 0 0", cpu_resetq, ram_wr, done);
      else
         pass_cnt++;
      total_cnt++;
      if ({busy, in_ready} !== 2'b11)
         $display("FAIL run_reload_rx: got busy=%b rdy=%b, required 1 1", busy, in_ready);
      else
         pass_cnt++;
      cpu_ram_wr = 1'b0;
      cpu_ram_a  = 16'h0000;
      cpu_ram_d  = 8'h00;
      mon_en     = 1'b1;
   endtask

   task automatic test_bad_frame();
      int bad;
      @(posedge clock); #1;
      payload = '{8'h01, 8'h02};
      send_frame(16'h0010, 8'h00, 0);
      @(negedge clock);
      total_cnt++;
      if ({err, done, in_ready, busy, cpu_resetq} !== 5'b10000)
         $display("FAIL bad_flags: got err=%b done=%b rdy=%b busy=%b rq=%b, required 1 0 0 0 0",
                  err, done, in_ready, busy, cpu_resetq);
      else
         pass_cnt++;
      @(posedge clock); #1;
      in_valid = 1'b1;
      bad = 0;
      for (int j = 0; j < 6; j++) begin
         @(negedge clock);
         if (in_ready !== 1'b0 || cpu_resetq !== 1'b0) bad++;
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
      total_cnt++;
      if (bad != 0)
         $display("FAIL error_hold: got %0d cycles with rdy/rq high, required 0", bad);
      else
         pass_cnt++;
      pulse_reload();
      @(negedge clock);
      total_cnt++;
      if ({err, busy} !== 2'b01)
         $display("FAIL error_reload: got err=%b busy=%b, required 0 1", err, busy);
      else
         pass_cnt++;
      @(posedge clock); #1;
      send_frame(16'h0010, good_csum(), 0);
      finish_good_frame("retry");
   endtask

   task automatic test_wrap();
      @(posedge clock); #1;
      pulse_reload();
      payload = '{8'h11, 8'h22};
      send_frame(16'hFFFF, 8'hCD, 0);
      finish_good_frame("wrap");
   endtask

   task automatic test_len_zero();
      @(posedge clock); #1;
      pulse_reload();
      payload.delete();
      send_frame(16'h0100, 8'h00, 0);
      finish_good_frame("len_zero");
   endtask

   task automatic test_reload_mid_data();
      @(posedge clock); #1;
      pulse_reload();
      send_byte(8'h00, 0);
      send_byte(8'h20, 0);
      send_byte(8'h00, 0);
      send_byte(8'h04, 0);
      exp_q.push_back('{a: 16'h0020, d: 8'h5A});
      send_byte(8'h5A, 0);
      exp_q.push_back('{a: 16'h0021, d: 8'h6B});
      send_byte(8'h6B, 0);
      in_valid = 1'b1;
      in_data  = 8'h7C;
      reload   = 1'b1;
      @(negedge clock);
      total_cnt++;
      if (in_ready !== 1'b0)
         $display("FAIL reload_ready: got %b, required 0", in_ready);
      else
         pass_cnt++;
      @(posedge clock); #1;
      reload   = 1'b0;
      in_valid = 1'b0;
      @(negedge clock);
      total_cnt++;
      if ({ram_wr, busy, in_ready, done} !== 4'b0110)
         $display("FAIL reload_mid: got wr=%b busy=%b rdy=%b done=%b, required 0 1 1 0",
                  ram_wr, busy, in_ready, done);
      else
         pass_cnt++;
      total_cnt++;
      if (exp_q.size() !== 0)
         $display("FAIL reload_mid_writes: got %0d pending, required 0", exp_q.size());
      else
         pass_cnt++;
      @(posedge clock); #1;
      payload = '{8'h10, 8'h20, 8'h30, 8'h40};
      send_frame(16'h0020, good_csum(), 0);
      finish_good_frame("after_reload");
   endtask

   task automatic test_random_gaps();
      @(posedge clock); #1;
      pulse_reload();
      payload = '{8'hA1, 8'hB2, 8'hC3};
      send_frame(16'h0010, 8'hEA, 3);
      finish_good_frame("gaps_basic");
      pulse_reload();
      payload.delete();
      for (int i = 0; i < 16; i++) payload.push_back(8'($urandom));
      send_frame(16'h0300, good_csum(), 3);
      finish_good_frame("gaps_random");
      pulse_reload();
      send_frame(16'h0400, good_csum() + 8'h01, 2);
      repeat (2) @(negedge clock);
      total_cnt++;
      if ({err, done, cpu_resetq} !== 3'b100)
         $display("FAIL gaps_bad: got err=%b done=%b rq=%b, required 1 0 0", err, done, cpu_resetq);
      else
         pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_run_mux_reload();
      test_bad_frame();
      test_wrap();
      test_len_zero();
      test_reload_mid_data();
      test_random_gaps();
      repeat (3) @(posedge clock);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

`default_nettype wire
